// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the system memory controller: access sizes, FSM
// states, port identifiers and the default RAM read latency.
package mem_ctrl_pkg;

  localparam int RD_LAT_DEFAULT = 2;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BAD  = 2'b11;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // A request is illegal for the reserved size code or a misaligned half/word.
  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      SIZE_WORD: return (addr_lo != 2'b00);
      SIZE_BAD:  return 1'b1;
      default:   return 1'b1;
    endcase
  endfunction

  // Index of the final byte of an access (byte count minus one).
  function automatic logic [1:0] last_byte(input logic [1:0] size);
    case (size)
      SIZE_HALF: return 2'd1;
      SIZE_WORD: return 2'd3;
      default:   return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. Bit 0 is the cpu port, bit 1 the debug
// port. On a tie the port that did not win last time is granted; after reset
// the cpu port has priority.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] grant
);

  // prio_reg = 0 favours bit 0 (cpu), 1 favours bit 1 (dbg)
  logic prio_reg;

  // Combinational grant, only while the controller can accept a request
  always_comb begin
    grant = 2'b00;
    if (grant_en) begin
      if (req == 2'b11) begin
        grant = prio_reg ? 2'b10 : 2'b01;
      end else begin
        grant = req;
      end
    end
  end

  // Hand priority to the other port whenever a grant is issued
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_reg <= 1'b0;
    end else if (|grant) begin
      prio_reg <= grant[0];
    end
  end

endmodule

// File: rtl/sys_mem_ctrl.sv
// System memory controller: arbitrates a cpu and a debug port onto a single
// byte-wide RAM, splitting half/word accesses into little-endian byte
// accesses and waiting RD_LAT clocks for each read byte.
module sys_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic [15:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [1:0]  dbg_size,
  input  logic [15:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic        dbg_err,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic        ram_wren,
  output logic        ram_rden,
  output logic [3:0]  ram_byteena,
  input  logic [7:0]  ram_q
);

  localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

  state_t      state_reg, state_next;
  logic        port_reg,  port_next;
  logic        we_reg,    we_next;
  logic [1:0]  size_reg,  size_next;
  logic [15:0] addr_reg,  addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [1:0]  idx_reg,   idx_next;
  logic [1:0]  wait_reg,  wait_next;
  logic [31:0] data_reg,  data_next;
  logic        err_reg,   err_next;

  logic [31:0] cpu_rdata_reg, dbg_rdata_reg;
  logic        cpu_err_reg,   dbg_err_reg;

  logic [1:0]  grant;
  logic        grant_sel;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      ({dbg_req, cpu_req}),
    .grant_en (state_reg == S_IDLE),
    .grant    (grant)
  );

  assign grant_sel = grant[1];

  // Next-state and RAM strobe decode; RAM outputs are only active in ISSUE
  always_comb begin
    state_next = state_reg;
    port_next  = port_reg;
    we_next    = we_reg;
    size_next  = size_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    idx_next   = idx_reg;
    wait_next  = wait_reg;
    data_next  = data_reg;
    err_next   = err_reg;
    ram_addr   = 16'h0000;
    ram_data   = 8'h00;
    ram_wren   = 1'b0;
    ram_rden   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (|grant) begin
          port_next  = grant_sel ? PORT_DBG : PORT_CPU;
          we_next    = grant_sel ? dbg_we    : cpu_we;
          size_next  = grant_sel ? dbg_size  : cpu_size;
          addr_next  = grant_sel ? dbg_addr  : cpu_addr;
          wdata_next = grant_sel ? dbg_wdata : cpu_wdata;
          idx_next   = 2'd0;
          wait_next  = WAIT_INIT;
          data_next  = 32'h0;
          if (is_illegal(size_next, addr_next[1:0])) begin
            err_next   = 1'b1;
            state_next = S_DONE;
          end else begin
            err_next   = 1'b0;
            state_next = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        ram_addr = addr_reg + {14'd0, idx_reg};
        if (we_reg) begin
          ram_wren = 1'b1;
          ram_data = wdata_reg[{idx_reg, 3'b000} +: 8];
          if (idx_reg == last_byte(size_reg)) begin
            state_next = S_DONE;
          end else begin
            idx_next = idx_reg + 2'd1;
          end
        end else begin
          ram_rden   = 1'b1;
          wait_next  = WAIT_INIT;
          state_next = S_WAIT;
        end
      end

      S_WAIT: begin
        if (wait_reg == 2'd0) begin
          data_next[{idx_reg, 3'b000} +: 8] = ram_q;
          if (idx_reg == last_byte(size_reg)) begin
            state_next = S_DONE;
          end else begin
            idx_next   = idx_reg + 2'd1;
            state_next = S_ISSUE;
          end
        end else begin
          wait_next = wait_reg - 2'd1;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Transaction registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      port_reg  <= PORT_CPU;
      we_reg    <= 1'b0;
      size_reg  <= SIZE_BYTE;
      addr_reg  <= 16'h0;
      wdata_reg <= 32'h0;
      idx_reg   <= 2'd0;
      wait_reg  <= 2'd0;
      data_reg  <= 32'h0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      port_reg  <= port_next;
      we_reg    <= we_next;
      size_reg  <= size_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      idx_reg   <= idx_next;
      wait_reg  <= wait_next;
      data_reg  <= data_next;
      err_reg   <= err_next;
    end
  end

  // Per-port result registers, loaded on entry to DONE and held until the next ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rdata_reg <= 32'h0;
      cpu_err_reg   <= 1'b0;
      dbg_rdata_reg <= 32'h0;
      dbg_err_reg   <= 1'b0;
    end else if (state_next == S_DONE && state_reg != S_DONE) begin
      if (port_next == PORT_DBG) begin
        dbg_rdata_reg <= data_next;
        dbg_err_reg   <= err_next;
      end else begin
        cpu_rdata_reg <= data_next;
        cpu_err_reg   <= err_next;
      end
    end
  end

  assign cpu_ack     = (state_reg == S_DONE) && (port_reg == PORT_CPU);
  assign dbg_ack     = (state_reg == S_DONE) && (port_reg == PORT_DBG);
  assign cpu_rdata   = cpu_rdata_reg;
  assign cpu_err     = cpu_err_reg;
  assign dbg_rdata   = dbg_rdata_reg;
  assign dbg_err     = dbg_err_reg;
  assign ram_byteena = 4'hF;

endmodule

// File: tb/tb_sys_mem_ctrl.sv
// Self-checking bench for sys_mem_ctrl with a behavioural byte RAM.
module tb_sys_mem_ctrl;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [1:0]  cpu_size = 2'b00;
  logic [15:0] cpu_addr = 16'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic        cpu_ack, cpu_err;
  logic [31:0] cpu_rdata;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [1:0]  dbg_size = 2'b00;
  logic [15:0] dbg_addr = 16'h0;
  logic [31:0] dbg_wdata = 32'h0;
  logic        dbg_ack, dbg_err;
  logic [31:0] dbg_rdata;
  logic [15:0] ram_addr;
  logic [7:0]  ram_data, ram_q;
  logic        ram_wren, ram_rden;
  logic [3:0]  ram_byteena;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acks_seen = 0;
  int last_ack = 0;
  int acc_cnt = 0;

  typedef struct {
    bit          port;
    bit          we;
    logic [1:0]  size;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    bit          chk_rd;
    int          lat;
    int          nacc;
  } vec_t;

  typedef struct {
    bit          port;
    logic [31:0] rdata;
    bit          err;
    bit          chk_rd;
    int          lat;
    int          nacc;
    int          start;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  sys_mem_ctrl #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_size(dbg_size), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_rden(ram_rden),
    .ram_byteena(ram_byteena), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 64 KiB RAM, q valid RD_LAT clocks after the read address
  logic [7:0] mem [0:65535] = '{default: 8'h00};
  logic [7:0] pipe [0:2];
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    pipe[0] <= mem[ram_addr];
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end
  assign ram_q = pipe[RD_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every ack pops one expectation
  always @(negedge clk) begin
    if (!rst) begin
      acc_cnt = 0;
    end else begin
      if (ram_wren || ram_rden) acc_cnt++;
      if (cpu_ack && dbg_ack) check("both_ack", 32'd1, 32'd0);
      if (cpu_ack || dbg_ack) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.start < 0) mon_e.start = last_ack + 1;
          check("ack_port", {31'd0, dbg_ack}, {31'd0, mon_e.port});
          check("ack_err", {31'd0, (mon_e.port ? dbg_err : cpu_err)}, {31'd0, mon_e.err});
          if (mon_e.chk_rd)
            check("ack_rdata", mon_e.port ? dbg_rdata : cpu_rdata, mon_e.rdata);
          check("ack_latency", 32'(cyc - mon_e.start), 32'(mon_e.lat));
          check("ram_accesses", 32'(acc_cnt), 32'(mon_e.nacc));
        end
        $display("txn ack port=%0d cpu_rdata=%08h dbg_rdata=%08h cyc=%0d", dbg_ack, cpu_rdata, dbg_rdata, cyc);
        last_ack = cyc;
        acc_cnt = 0;
        acks_seen++;
      end
    end
  end

  task automatic wait_acks(input int target, input string name);
    int k;
    k = 0;
    while (acks_seen < target && k < 300) begin
      @(negedge clk); #1;
      k++;
    end
    check(name, {31'd0, acks_seen >= target}, 32'd1);
  endtask

  task automatic drive(input vec_t v);
    if (v.port) begin
      dbg_req = 1'b1; dbg_we = v.we; dbg_size = v.size; dbg_addr = v.addr; dbg_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_size = v.size; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
  endtask

  function automatic exp_t mk_exp(input vec_t v, input int start);
    exp_t e;
    e.port = v.port; e.rdata = v.rdata; e.err = v.err; e.chk_rd = v.chk_rd;
    e.lat = v.lat; e.nacc = v.nacc; e.start = start;
    return e;
  endfunction

  task automatic run_one(input vec_t v);
    int n0;
    @(posedge clk); #1;
    drive(v);
    sb.push_back(mk_exp(v, cyc));
    n0 = acks_seen;
    wait_acks(n0 + 1, "ack_timeout");
    cpu_req = 1'b0;
    dbg_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_ack"}, {31'd0, cpu_ack}, 32'd0);
    check({tag, "_dbg_ack"}, {31'd0, dbg_ack}, 32'd0);
    check({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
    check({tag, "_cpu_err"}, {31'd0, cpu_err}, 32'd0);
    check({tag, "_dbg_rdata"}, dbg_rdata, 32'd0);
    check({tag, "_ram_wren"}, {31'd0, ram_wren}, 32'd0);
    check({tag, "_ram_rden"}, {31'd0, ram_rden}, 32'd0);
    check({tag, "_ram_addr"}, {16'd0, ram_addr}, 32'd0);
    check({tag, "_ram_data"}, {24'd0, ram_data}, 32'd0);
    check({tag, "_byteena"}, {28'd0, ram_byteena}, 32'hF);
  endtask

  vec_t vecs [11];
  vec_t va, vb;
  int g;

  initial begin
    // port, we, size, addr, wdata, rdata, err, chk_rd, lat, nacc
    vecs[0]  = '{0, 1, 2'b10, 16'h0010, 32'hDEADBEEF, 32'h0,        0, 0, 5,  4};
    vecs[1]  = '{0, 0, 2'b10, 16'h0010, 32'h0,        32'hDEADBEEF, 0, 1, 13, 4};
    vecs[2]  = '{1, 0, 2'b01, 16'h0012, 32'h0,        32'h0000DEAD, 0, 1, 7,  2};
    vecs[3]  = '{0, 0, 2'b00, 16'h0011, 32'h0,        32'h000000BE, 0, 1, 4,  1};
    vecs[4]  = '{0, 1, 2'b10, 16'h0013, 32'h12345678, 32'h0,        1, 1, 1,  0};
    vecs[5]  = '{0, 0, 2'b11, 16'h0020, 32'h0,        32'h0,        1, 1, 1,  0};
    vecs[6]  = '{1, 1, 2'b00, 16'h0100, 32'hAAAAAA55, 32'h0,        0, 0, 2,  1};
    vecs[7]  = '{1, 0, 2'b00, 16'h0100, 32'h0,        32'h00000055, 0, 1, 4,  1};
    vecs[8]  = '{0, 1, 2'b01, 16'h0200, 32'hFFFF1234, 32'h0,        0, 0, 3,  2};
    vecs[9]  = '{0, 0, 2'b10, 16'h0200, 32'h0,        32'h00001234, 0, 1, 13, 4};
    vecs[10] = '{1, 1, 2'b01, 16'h0201, 32'h0000BEEF, 32'h0,        1, 1, 1,  0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    @(negedge clk);
    rst = 1'b1;

    // Table-driven single transactions
    for (int i = 0; i < 11; i++) run_one(vecs[i]);

    check("mem_10", {24'd0, mem[16'h0010]}, 32'hEF);
    check("mem_11", {24'd0, mem[16'h0011]}, 32'hBE);
    check("mem_12", {24'd0, mem[16'h0012]}, 32'hAD);
    check("mem_13", {24'd0, mem[16'h0013]}, 32'hDE);
    check("mem_100", {24'd0, mem[16'h0100]}, 32'h55);
    check("mem_101", {24'd0, mem[16'h0101]}, 32'h00);
    check("mem_202", {24'd0, mem[16'h0202]}, 32'h00);
    check("mem_201", {24'd0, mem[16'h0201]}, 32'h12);

    // Arbitration: both ports held for four transactions
    va = '{0, 0, 2'b00, 16'h0011, 32'h0, 32'h000000BE, 0, 1, 4, 1};
    vb = '{1, 0, 2'b00, 16'h0010, 32'h0, 32'h000000EF, 0, 1, 4, 1};
    @(posedge clk); #1;
    drive(va);
    drive(vb);
    g = acks_seen;
    sb.push_back(mk_exp(va, cyc));
    sb.push_back(mk_exp(vb, -1));
    sb.push_back(mk_exp(va, -1));
    sb.push_back(mk_exp(vb, -1));
    wait_acks(g + 4, "rr_timeout");
    cpu_req = 1'b0;
    dbg_req = 1'b0;

    // Reset during the third byte of a word store
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b10; cpu_addr = 16'h0300; cpu_wdata = 32'hA1B2C3D4;
    repeat (3) @(posedge clk);
    #1;
    check("abort_pre_addr", {16'd0, ram_addr}, 32'h0302);
    check("abort_pre_wren", {31'd0, ram_wren}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("abort_mem_300", {24'd0, mem[16'h0300]}, 32'hD4);
    check("abort_mem_301", {24'd0, mem[16'h0301]}, 32'hC3);
    check("abort_mem_302", {24'd0, mem[16'h0302]}, 32'h00);
    check("abort_mem_303", {24'd0, mem[16'h0303]}, 32'h00);

    // After reset the cpu port wins a tie again
    va = '{0, 0, 2'b10, 16'h0300, 32'h0, 32'h0000C3D4, 0, 1, 13, 4};
    vb = '{1, 0, 2'b00, 16'h0301, 32'h0, 32'h000000C3, 0, 1, 4,  1};
    @(posedge clk); #1;
    drive(va);
    drive(vb);
    g = acks_seen;
    sb.push_back(mk_exp(va, cyc));
    sb.push_back(mk_exp(vb, -1));
    wait_acks(g + 2, "post_rst_timeout");
    cpu_req = 1'b0;
    dbg_req = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("cpu_rdata_hold", cpu_rdata, 32'h0000C3D4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sys_mem_ctrl.md
SYS_MEM_CTRL -- requirements
Module: sys_mem_ctrl

Interface
REQ-001 The block SHALL have the parameter RD_LAT, default 2, giving the system_ram read latency in clocks from address/rden to valid q (legal 1..3).
REQ-002 The block SHALL have these ports, one clock, reset asynchronous and active-low:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU request, held high until cpu_ack
- cpu_we  in  1  1 = store, 0 = load
- cpu_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- cpu_addr  in  16  byte address
- cpu_wdata  in  32  store data, little-endian
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  32  zero-extended load data, valid with cpu_ack
- cpu_err  out  1  misaligned/illegal flag, valid with cpu_ack
- dbg_req, dbg_we, dbg_size, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata, dbg_err  same as cpu_* for the debug port
- ram_addr  out  16  system_ram address
- ram_data  out  8  system_ram write byte
- ram_wren  out  1  system_ram write enable
- ram_rden  out  1  system_ram read enable
- ram_byteena  out  4  constant 4'hF
- ram_q  in  8  system_ram read byte

Function
REQ-003 The block SHALL serialise each 8/16/32-bit access into 1/2/4 byte accesses at addr, addr+1, addr+2, addr+3, byte 0 = bits [7:0].
REQ-004 The FSM SHALL have states IDLE, ISSUE, WAIT, DONE; any other encoding SHALL return to IDLE.
REQ-005 In IDLE, on any req, the block SHALL grant one port, latch we/size/addr/wdata/port-id and move to ISSUE, or to DONE when the access is illegal.
REQ-006 Arbitration SHALL be round-robin: on simultaneous cpu_req and dbg_req the port not granted last wins; after reset the cpu port is favoured first.
REQ-007 A request SHALL be illegal when size = 11, half with addr[0] = 1, or word with addr[1:0] != 00; an illegal request SHALL cause no RAM access and SHALL ack with err = 1, rdata = 0.
REQ-008 In ISSUE the block SHALL drive ram_addr = latched addr + byte index for exactly one cycle, with ram_wren = 1 and ram_data = the selected wdata byte for stores, or ram_rden = 1 for loads.
REQ-009 For a store, ISSUE SHALL advance to the next byte, or to DONE after the last byte; for a load, ISSUE SHALL go to WAIT.
REQ-010 WAIT SHALL last RD_LAT cycles with ram_rden = ram_wren = 0, capture ram_q into the indexed rdata byte on its final cycle, then go to ISSUE for the next byte or to DONE.
REQ-011 DONE SHALL assert exactly one ack, on the granted port only, with rdata/err, for one cycle, then return to IDLE; rdata/err SHALL hold until the next ack on that port.
REQ-012 Latency from the grant cycle to ack SHALL be: illegal 1; store N+1; load N*(1+RD_LAT)+1, where N is the byte count.
REQ-013 Deassertion of req or changes to request inputs after grant SHALL be ignored; the latched transaction SHALL complete.
REQ-014 A req asserted during DONE SHALL NOT be granted until the following IDLE cycle, giving a minimum of 1 IDLE cycle between transactions.
REQ-015 Unloaded rdata bytes SHALL be 0 (byte load -> [31:8] = 0, half -> [31:16] = 0).

Reset
REQ-016 While rst = 0, the block SHALL hold the state at IDLE, the round-robin pointer at cpu, and all outputs at 0 except ram_byteena = 4'hF.
REQ-017 Reset mid-transaction SHALL abort it with no ack; RAM bytes already written SHALL NOT be undone.

Structure
REQ-018 The package mem_ctrl_pkg SHALL hold the size encodings, the state encoding and the RD_LAT default.
REQ-019 The two-requester round-robin SHALL be a sub-module named rr_arbiter2 (req[1:0], grant_en -> grant[1:0], pointer update on grant).

Verification
REQ-020 The bench SHALL use a behavioural 64 KiB byte RAM model with RD_LAT = 2 and cover:
- cpu word store 0xDEADBEEF @0x0010 -> RAM[0x10..0x13] = EF,BE,AD,DE; cpu_ack 5 cycles after grant.
- cpu word load @0x0010 -> cpu_rdata = 0xDEADBEEF, err = 0, ack 13 cycles after grant.
- dbg half load @0x0012 -> dbg_rdata = 0x0000DEAD; cpu byte load @0x0011 -> 0x000000BE.
- cpu word @0x0013 and size 11 -> err = 1, rdata = 0, no ram_wren/ram_rden, ack 1 cycle after grant.
- cpu_req and dbg_req both held for 4 transactions -> grants alternate cpu, dbg, cpu, dbg; no ack on the non-granted port.
- rst low during the 3rd byte of a word store -> outputs 0 immediately, no ack, first two bytes written, next request served normally.
